// File: rtl/multi_mode_ff_bank.sv
// Bank of WIDTH flip-flops that act as SR, JK, D or T cells, all in the same mode.
// Also provides parallel load, sticky SR-invalid flags and a saturating change counter.
module multi_mode_ff_bank #(
  parameter int WIDTH   = 4,
  parameter int CNT_W   = 8,
  parameter int SR_BOTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] err,
  output logic             err_any,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] err_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] fn_q;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] err_set;
  logic [WIDTH-1:0] err_next;

  // Per-bit cell function for the current mode; untouched bits hold.
  always_comb begin
    fn_q = q_r;
    for (int i = 0; i < WIDTH; i++) begin
      case (mode)
        MODE_SR: begin
          case ({a[i], b[i]})
            2'b10: fn_q[i] = 1'b1;
            2'b01: fn_q[i] = 1'b0;
            2'b11: begin
              // Any SR_BOTH value other than 1 or 2 keeps the bit.
              if (SR_BOTH == 1)      fn_q[i] = 1'b1;
              else if (SR_BOTH == 2) fn_q[i] = 1'b0;
            end
            default: ;
          endcase
        end
        MODE_JK: begin
          case ({a[i], b[i]})
            2'b10:   fn_q[i] = 1'b1;
            2'b01:   fn_q[i] = 1'b0;
            2'b11:   fn_q[i] = ~q_r[i];
            default: ;
          endcase
        end
        MODE_D: fn_q[i] = a[i];
        MODE_T: if (a[i]) fn_q[i] = ~q_r[i];
        default: ;
      endcase
    end
  end

  always_comb begin
    q_next   = load ? ld_val : (en ? fn_q : q_r);
    err_set  = (en && !load && mode == MODE_SR) ? (a & b) : '0;
    // A fresh error on the clearing edge survives the clear.
    err_next = (err_clr ? '0 : err_r) | err_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r   <= '0;
      err_r <= '0;
      cnt_r <= '0;
    end else begin
      q_r   <= q_next;
      err_r <= err_next;
      if (q_next != q_r && cnt_r != CNT_MAX) cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign q       = q_r;
  assign qbar    = ~q_r;
  assign err     = err_r;
  assign err_any = |err_r;
  assign chg_cnt = cnt_r;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Bench for multi_mode_ff_bank: two instances (SR_BOTH=0/CNT_W=8 and SR_BOTH=2/CNT_W=2)
// share stimulus and are checked against a behavioural model of the cell rules.
module tb_multi_mode_ff_bank;

  logic       clk;
  logic       rst, en, load, err_clr;
  logic [1:0] mode;
  logic [3:0] a, b, ld_val;

  logic [3:0] q_a, qbar_a, err_a;
  logic       err_any_a;
  logic [7:0] cnt_a;
  logic [3:0] q_b, qbar_b, err_b;
  logic       err_any_b;
  logic [1:0] cnt_b;

  int n_vec = 0;
  int n_err = 0;

  // Model state, index 0 = u_a, index 1 = u_b
  logic [3:0] m_q   [2];
  logic [3:0] m_err [2];
  int         m_cnt [2];
  int         srb     [2] = '{0, 2};
  int         cnt_max [2] = '{255, 3};

  multi_mode_ff_bank #(.WIDTH(4), .CNT_W(8), .SR_BOTH(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .load(load),
    .ld_val(ld_val), .err_clr(err_clr), .q(q_a), .qbar(qbar_a), .err(err_a),
    .err_any(err_any_a), .chg_cnt(cnt_a)
  );

  multi_mode_ff_bank #(.WIDTH(4), .CNT_W(2), .SR_BOTH(2)) u_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .load(load),
    .ld_val(ld_val), .err_clr(err_clr), .q(q_b), .qbar(qbar_b), .err(err_b),
    .err_any(err_any_b), .chg_cnt(cnt_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: apply the cell rules to the inputs held at this edge.
  function automatic void model_step();
    for (int k = 0; k < 2; k++) begin
      logic [3:0] nq;
      logic [3:0] ne;
      if (rst) begin
        m_q[k] = 4'b0; m_err[k] = 4'b0; m_cnt[k] = 0;
      end else begin
        nq = m_q[k];
        if (load) nq = ld_val;
        else if (en) begin
          for (int i = 0; i < 4; i++) begin
            case (mode)
              2'd0: begin
                if (a[i] && !b[i]) nq[i] = 1'b1;
                else if (!a[i] && b[i]) nq[i] = 1'b0;
                else if (a[i] && b[i])
                  nq[i] = (srb[k] == 1) ? 1'b1 : (srb[k] == 2) ? 1'b0 : m_q[k][i];
              end
              2'd1: begin
                if (a[i] && b[i]) nq[i] = ~m_q[k][i];
                else if (a[i]) nq[i] = 1'b1;
                else if (b[i]) nq[i] = 1'b0;
              end
              2'd2: nq[i] = a[i];
              default: if (a[i]) nq[i] = ~m_q[k][i];
            endcase
          end
        end
        ne = err_clr ? 4'b0 : m_err[k];
        if (en && !load && mode == 2'd0) ne = ne | (a & b);
        if (nq != m_q[k] && m_cnt[k] < cnt_max[k]) m_cnt[k] = m_cnt[k] + 1;
        m_q[k] = nq;
        m_err[k] = ne;
      end
    end
  endfunction

  // Driver: present inputs, take one edge, update model, settle before checks.
  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic [3:0] av, input logic [3:0] bv, input logic l,
                      input logic [3:0] lv, input logic c);
    rst = r; en = e; mode = m; a = av; b = bv; load = l; ld_val = lv; err_clr = c;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 2'd3, 4'hF, 4'hF, 1, 4'hA, 0);
    n_vec++; if (q_a !== 4'b0000) begin $display("FAIL reset_q act=%b exp=0000", q_a); n_err++; end
    n_vec++; if (qbar_a !== 4'b1111) begin $display("FAIL reset_qbar act=%b exp=1111", qbar_a); n_err++; end
    n_vec++; if (err_a !== 4'b0000 || err_any_a !== 1'b0) begin $display("FAIL reset_err act=%b/%b exp=0000/0", err_a, err_any_a); n_err++; end
    n_vec++; if (cnt_a !== 8'd0 || cnt_b !== 2'd0) begin $display("FAIL reset_cnt act=%0d/%0d exp=0/0", cnt_a, cnt_b); n_err++; end
  endtask

  task automatic test_d_mode();
    step(1, 0, 2'd0, 4'h0, 4'h0, 0, 4'h0, 0);
    step(0, 1, 2'd2, 4'b1010, 4'b0000, 0, 4'h0, 0);
    n_vec++; if (q_a !== 4'b1010 || qbar_a !== 4'b0101) begin $display("FAIL d_q act=%b/%b exp=1010/0101", q_a, qbar_a); n_err++; end
    n_vec++; if (cnt_a !== 8'd1) begin $display("FAIL d_cnt act=%0d exp=1", cnt_a); n_err++; end
  endtask

  task automatic test_sr_error();
    step(1, 0, 2'd0, 4'h0, 4'h0, 0, 4'h0, 0);
    step(0, 1, 2'd0, 4'b0011, 4'b0101, 0, 4'h0, 0);
    n_vec++; if (q_a !== 4'b0010 || q_b !== 4'b0010) begin $display("FAIL sr_q act=%b/%b exp=0010/0010", q_a, q_b); n_err++; end
    n_vec++; if (err_a !== 4'b0001 || err_any_a !== 1'b1) begin $display("FAIL sr_err act=%b/%b exp=0001/1", err_a, err_any_a); n_err++; end
    step(0, 1, 2'd0, 4'h0, 4'h0, 0, 4'h0, 1);
    n_vec++; if (err_a !== 4'b0000 || err_any_a !== 1'b0) begin $display("FAIL sr_clr act=%b/%b exp=0000/0", err_a, err_any_a); n_err++; end
  endtask

  task automatic test_jk_toggle();
    logic [3:0] exp_q;
    step(1, 0, 2'd0, 4'h0, 4'h0, 0, 4'h0, 0);
    exp_q = 4'b0000;
    for (int n = 0; n < 3; n++) begin
      step(0, 1, 2'd1, 4'hF, 4'hF, 0, 4'h0, 0);
      exp_q = ~exp_q;
      n_vec++; if (q_a !== exp_q || q_b !== exp_q) begin $display("FAIL jk_q%0d act=%b/%b exp=%b", n, q_a, q_b, exp_q); n_err++; end
    end
    n_vec++; if (cnt_a !== 8'd3 || cnt_b !== 2'd3) begin $display("FAIL jk_cnt act=%0d/%0d exp=3/3", cnt_a, cnt_b); n_err++; end
    n_vec++; if (err_a !== 4'b0000) begin $display("FAIL jk_err act=%b exp=0000", err_a); n_err++; end
  endtask

  task automatic test_t_saturate();
    step(1, 0, 2'd0, 4'h0, 4'h0, 0, 4'h0, 0);
    for (int n = 0; n < 5; n++) begin
      step(0, 1, 2'd3, 4'b0001, 4'hF, 0, 4'h0, 0);
      n_vec++; if (q_b[0] !== ((n % 2) == 0)) begin $display("FAIL t_q0_%0d act=%b exp=%b", n, q_b[0], (n % 2) == 0); n_err++; end
    end
    n_vec++; if (cnt_b !== 2'd3 || cnt_a !== 8'd5) begin $display("FAIL t_sat act=%0d/%0d exp=3/5", cnt_b, cnt_a); n_err++; end
  endtask

  task automatic test_load_reset();
    step(1, 0, 2'd0, 4'h0, 4'h0, 0, 4'h0, 0);
    step(0, 0, 2'd3, 4'hF, 4'h0, 1, 4'b0110, 0);
    n_vec++; if (q_a !== 4'b0110 || cnt_a !== 8'd1) begin $display("FAIL load_q act=%b/%0d exp=0110/1", q_a, cnt_a); n_err++; end
    step(1, 1, 2'd3, 4'hF, 4'h0, 1, 4'b0110, 1);
    n_vec++; if (q_a !== 4'b0000 || cnt_a !== 8'd0) begin $display("FAIL load_rst act=%b/%0d exp=0000/0", q_a, cnt_a); n_err++; end
  endtask

  task automatic test_err_set_wins();
    step(1, 0, 2'd0, 4'h0, 4'h0, 0, 4'h0, 0);
    step(0, 0, 2'd0, 4'h0, 4'h0, 1, 4'b0101, 0);
    step(0, 1, 2'd0, 4'b0001, 4'b0001, 0, 4'h0, 1);
    n_vec++; if (err_a !== 4'b0001 || err_b !== 4'b0001) begin $display("FAIL setwin_err act=%b/%b exp=0001/0001", err_a, err_b); n_err++; end
    n_vec++; if (q_a !== 4'b0101 || q_b !== 4'b0100) begin $display("FAIL setwin_q act=%b/%b exp=0101/0100", q_a, q_b); n_err++; end
    step(0, 0, 2'd0, 4'hF, 4'hF, 0, 4'h0, 0);
    n_vec++; if (err_a !== 4'b0001 || q_a !== 4'b0101 || q_b !== 4'b0100) begin $display("FAIL en0_hold act=%b/%b/%b exp=0001/0101/0100", err_a, q_a, q_b); n_err++; end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom_range(0, 6) == 0,
           4'($urandom_range(0, 15)), $urandom_range(0, 4) == 0);
      n_vec++;
      if (q_a !== m_q[0] || qbar_a !== ~m_q[0] || err_a !== m_err[0] ||
          err_any_a !== (|m_err[0]) || cnt_a !== 8'(m_cnt[0])) begin
        $display("FAIL rand_a%0d act=q%b qb%b e%b ea%b c%0d exp=q%b e%b c%0d",
                 n, q_a, qbar_a, err_a, err_any_a, cnt_a, m_q[0], m_err[0], m_cnt[0]);
        n_err++;
      end
      n_vec++;
      if (q_b !== m_q[1] || qbar_b !== ~m_q[1] || err_b !== m_err[1] ||
          err_any_b !== (|m_err[1]) || cnt_b !== 2'(m_cnt[1])) begin
        $display("FAIL rand_b%0d act=q%b qb%b e%b ea%b c%0d exp=q%b e%b c%0d",
                 n, q_b, qbar_b, err_b, err_any_b, cnt_b, m_q[1], m_err[1], m_cnt[1]);
        n_err++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; a = '0; b = '0;
    load = 1'b0; ld_val = '0; err_clr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_q[k] = '0; m_err[k] = '0; m_cnt[k] = 0;
    end
    test_reset();
    test_d_mode();
    test_sr_error();
    test_jk_toggle();
    test_t_saturate();
    test_load_reset();
    test_err_set_wins();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
